uart_rx_core: RTL and testbench

//  Serial UART receiver: oversamples the rx line using the baud-rate tick and reassembles LSB-first frames.

---
 rtl/uart_rx_core.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Oversampling UART receiver. Reassembles LSB-first serial frames from the
//   rx line using the baud-rate oversample enable s_tick. Each finished frame
//   produces a one-cycle rx_done_tick together with the received word and its
//   framing/parity status.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   - one even-parity bit follows the data bits; parity_err is
//                 registered with each strobe
//     undefined - data bits go straight to the stop bit; parity_err stays 0
//
// Ports
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous, active-high reset
//   rx           in   asynchronous serial line, idle high
//   s_tick       in   one-cycle oversample enable (OVS pulses per bit)
//   rx_done_tick out  one-cycle pulse: frame complete, dout/flags valid
//   dout         out  received word, bit 0 = first data bit on the line
//   frame_err    out  stop bit sampled low for the last frame
//   parity_err   out  parity mismatch for the last frame
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Even parity over data plus received parity bit: nonzero means mismatch.
    function automatic logic even_parity_err(input logic [DBIT-1:0] data,
                                             input logic            pbit);
        return ^{data, pbit};
    endfunction

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_d;
    logic            frame_err_d;
    logic            parity_err_d;
    logic            done_d;
    logic            rx_sync_p0;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
`endif

    // Stage p0/p1: two-flop synchronizer, preset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_s       <= rx_sync_p0;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        dout_d       = dout;
        frame_err_d  = frame_err;
        parity_err_d = parity_err;
        done_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                // Start edge is seen on any clock, not just on s_tick.
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_HALF) begin
                        // Mid start bit: a high line here was only a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d       = '0;
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        // Word and status update on the same edge as the strobe.
                        done_d      = 1'b1;
                        dout_d      = b_q;
                        frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = even_parity_err(b_q, par_bit_q);
`else
                        parity_err_d = 1'b0;
`endif
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p2: FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= frame_err_d;
            parity_err   <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Directed and randomized frames for uart_rx_core (DBIT=8, OVS=16,
//   SB_TICK=16, s_tick every 4 clk, 64 clk per bit). Expected words and
//   status flags come from the frame contents the bench chooses to send.
module tb_uart_rx_core;

    localparam int DBIT    = 8;
    localparam int OVS     = 16;
    localparam int SB_TICK = 16;
    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            rx;
    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] dout;
    logic            frame_err;
    logic            parity_err;

    typedef struct packed {
        logic [DBIT-1:0] d;
        logic            fe;
        logic            pe;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_q[$];
    int     checks      = 0;
    int     errors      = 0;
    int     wide_pulses = 0;

    uart_rx_core #(.DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Oversample enable: one clock high out of every four.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Capture every strobe; a strobe seen on consecutive cycles is too wide.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done_tick) begin
                got_q.push_back({dout, frame_err, parity_err});
                if (prev) wide_pulses++;
            end
            prev = rx_done_tick;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // Sends one frame and records what the receiver must report for it.
    task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_ok, input logic pbit);
        logic pe;
        pe = (PB != 0) ? (^d ^ pbit) : 1'b0;
        exp_q.push_back({d, ~stop_ok, pe});
        hold_line(1'b0, BIT_CLK);
        for (int i = 0; i < DBIT; i++) hold_line(d[i], BIT_CLK);
        if (PB != 0) hold_line(pbit, BIT_CLK);
        if (stop_ok) begin
            hold_line(1'b1, BIT_CLK);
        end else begin
            // Low across the sample point, then released so the re-armed
            // start check sees an idle line.
            hold_line(1'b0, 48);
            hold_line(1'b1, BIT_CLK - 48);
        end
    endtask

    task automatic compare_frames(input string tag);
        frame_t g;
        frame_t e;
        repeat (8) @(negedge clk);
        check({tag, " strobe count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, " dout"}, 32'(g.d), 32'(e.d));
            check({tag, " frame_err"}, 32'(g.fe), 32'(e.fe));
            check({tag, " parity_err"}, 32'(g.pe), 32'(e.pe));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DBIT-1:0] d;
        logic            ok;
        logic            pbit;
        logic            prev_bad;
        int              gap;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset dout", 32'(dout), 32'h0);
        check("reset rx_done_tick", 32'(rx_done_tick), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        reset = 1'b0;
        hold_line(1'b1, 20);

        // Single clean frame, exactly one strobe.
        send_frame(8'hA5, 1'b1, ^8'hA5);
        hold_line(1'b1, 200);
        compare_frames("a5");

        // Short low glitch is rejected and leaves outputs alone.
        hold_line(1'b0, 20);
        hold_line(1'b1, 200);
        compare_frames("glitch");
        check("glitch dout held", 32'(dout), 32'hA5);
        check("glitch frame_err held", 32'(frame_err), 32'h0);

        // Bad stop bit, then a good frame clears the framing flag.
        send_frame(8'h3C, 1'b0, ^8'h3C);
        hold_line(1'b1, 100);
        send_frame(8'h81, 1'b1, ^8'h81);
        hold_line(1'b1, 100);
        compare_frames("framing");
        check("frame_err after good", 32'(frame_err), 32'h0);

        // Reset in the middle of data bit 4 of 0xFF drops that frame.
        hold_line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold_line(1'b1, BIT_CLK);
        hold_line(1'b1, 30);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midreset dout", 32'(dout), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        hold_line(1'b1, BIT_CLK - 32 + 3 * BIT_CLK + BIT_CLK);
        send_frame(8'h12, 1'b1, ^8'h12);
        hold_line(1'b1, 100);
        compare_frames("midreset");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        hold_line(1'b1, 100);
        compare_frames("b2b");

        // Break: line low past the stop sample point, released before the
        // re-armed start check.
        exp_q.push_back({{DBIT{1'b0}}, 1'b1, 1'b0});
        hold_line(1'b0, (1 + DBIT + PB) * BIT_CLK + 48);
        hold_line(1'b1, 200);
        compare_frames("break");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        hold_line(1'b1, 100);
        send_frame(8'h07, 1'b1, 1'b0);
        hold_line(1'b1, 100);
        compare_frames("parity");
`endif

        // Random words, stop bits, parity bits and idle gaps.
        prev_bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            d    = DBIT'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            pbit = 1'($urandom);
            send_frame(d, ok, pbit);
            prev_bad = ~ok;
            gap = $urandom_range(0, 40);
            if (prev_bad) gap = gap + 40;
            hold_line(1'b1, gap);
        end
        hold_line(1'b1, 100);
        compare_frames("random");

        check("strobe width", 32'(wide_pulses), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
